// File: rtl/bk_mem_pkg.sv
// Shared definitions for the SRAM arbiter: access FSM states and the
// default number of SRAM wait states.
package bk_mem_pkg;

    localparam int WAIT_STATES_DEF = 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_VRD       = 3'd1,
        S_CRD       = 3'd2,
        S_CWR_SETUP = 3'd3,
        S_CWR       = 3'd4,
        S_CWR_HOLD  = 3'd5,
        S_CREPLY    = 3'd6
    } state_t;

endpackage

// File: rtl/bk_ram_lanes.sv
// Byte-lane decode for the 16-bit SRAM.
// Ports: i_byte (byte access), i_adr0 (lane select), i_wr (write access),
//        o_ub_n / o_lb_n (active-low lane enables).
// Reads always enable both lanes; the core extracts the byte itself.
module bk_ram_lanes (
    input  logic i_byte,
    input  logic i_adr0,
    input  logic i_wr,
    output logic o_ub_n,
    output logic o_lb_n
);

    logic w_byte_wr;

    assign w_byte_wr = i_byte & i_wr;
    assign o_ub_n    = w_byte_wr & ~i_adr0;
    assign o_lb_n    = w_byte_wr & i_adr0;

endmodule

// File: rtl/bk_ram_arbiter.sv
// Shares one 16-bit async SRAM between the CPU memory port and the video
// scan-out fetcher, driving the SRAM pins from a registered access FSM.
// Ports: clk/reset; CPU cpu_rd/cpu_wt/cpu_byte/cpu_adr/cpu_data_i in,
//        cpu_data_o/cpu_reply out; video vid_req/vid_adr in,
//        vid_data/vid_ack out; SRAM sram_a/sram_dq_o/sram_dq_oe/
//        sram_oe_n/sram_we_n/sram_ub_n/sram_lb_n out, sram_dq_i in.
module bk_ram_arbiter
    import bk_mem_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEF,
    parameter int AW          = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wt,
    input  logic          cpu_byte,
    input  logic [AW-1:0] cpu_adr,
    input  logic [15:0]   cpu_data_i,
    output logic [15:0]   cpu_data_o,
    output logic          cpu_reply,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_adr,
    output logic [15:0]   vid_data,
    output logic          vid_ack,
    output logic [AW-2:0] sram_a,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe,
    input  logic [15:0]   sram_dq_i,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    localparam int CW = $clog2(WAIT_STATES + 1) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_last_vid;
    logic [AW-2:0]   r_a;
    logic [15:0]     r_dq_o;
    logic            r_dq_oe;
    logic            r_oe_n;
    logic            r_we_n;
    logic            r_ub_n;
    logic            r_lb_n;
    logic [15:0]     r_cpu_data;
    logic [15:0]     r_vid_data;
    logic            r_cpu_reply;
    logic            r_vid_ack;

    logic            w_cpu_pend;
    logic            w_vid_win;
    logic            w_ub_n;
    logic            w_lb_n;
    logic            w_unused_vid_a0;

    // Video word fetches ignore the byte bit.
    assign w_unused_vid_a0 = vid_adr[0];

    assign w_cpu_pend = cpu_rd | cpu_wt;
    // Video wins unless it had the previous slot and the CPU is waiting.
    assign w_vid_win  = vid_req & ~(r_last_vid & w_cpu_pend);

    bk_ram_lanes u_lanes (
        .i_byte (cpu_byte),
        .i_adr0 (cpu_adr[0]),
        .i_wr   (cpu_wt),
        .o_ub_n (w_ub_n),
        .o_lb_n (w_lb_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_vid  <= 1'b0;
            r_a         <= '0;
            r_dq_o      <= '0;
            r_dq_oe     <= 1'b0;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_cpu_data  <= '0;
            r_vid_data  <= '0;
            r_cpu_reply <= 1'b0;
            r_vid_ack   <= 1'b0;
        end else begin
            r_vid_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_vid_win) begin
                        r_state    <= S_VRD;
                        r_last_vid <= 1'b1;
                        r_a        <= vid_adr[AW-1:1];
                        r_oe_n     <= 1'b0;
                        r_ub_n     <= 1'b0;
                        r_lb_n     <= 1'b0;
                        r_cnt      <= CNT_INIT;
                    end else if (cpu_wt) begin
                        r_state    <= S_CWR_SETUP;
                        r_last_vid <= 1'b0;
                        r_a        <= cpu_adr[AW-1:1];
                        r_dq_o     <= cpu_data_i;
                        r_dq_oe    <= 1'b1;
                        r_ub_n     <= w_ub_n;
                        r_lb_n     <= w_lb_n;
                    end else if (cpu_rd) begin
                        r_state    <= S_CRD;
                        r_last_vid <= 1'b0;
                        r_a        <= cpu_adr[AW-1:1];
                        r_oe_n     <= 1'b0;
                        r_ub_n     <= w_ub_n;
                        r_lb_n     <= w_lb_n;
                        r_cnt      <= CNT_INIT;
                    end
                end
                S_VRD, S_CRD: begin
                    if (r_cnt == '0) begin
                        r_oe_n <= 1'b1;
                        r_ub_n <= 1'b1;
                        r_lb_n <= 1'b1;
                        if (r_state == S_VRD) begin
                            r_vid_data <= sram_dq_i;
                            r_vid_ack  <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cpu_data  <= sram_dq_i;
                            r_cpu_reply <= 1'b1;
                            r_state     <= S_CREPLY;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CWR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= CNT_INIT;
                    r_state <= S_CWR;
                end
                S_CWR: begin
                    if (r_cnt == '0) begin
                        r_we_n  <= 1'b1;
                        r_state <= S_CWR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_CWR_HOLD: begin
                    // Data held one cycle past we_n rising for hold time.
                    r_dq_oe     <= 1'b0;
                    r_ub_n      <= 1'b1;
                    r_lb_n      <= 1'b1;
                    r_cpu_reply <= 1'b1;
                    r_state     <= S_CREPLY;
                end
                S_CREPLY: begin
                    // Waiting for strobes to drop doubles as bus turnaround.
                    if (!w_cpu_pend) begin
                        r_cpu_reply <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_data_o = r_cpu_data;
    assign cpu_reply  = r_cpu_reply;
    assign vid_data   = r_vid_data;
    assign vid_ack    = r_vid_ack;
    assign sram_a     = r_a;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_ub_n  = r_ub_n;
    assign sram_lb_n  = r_lb_n;

endmodule

// File: tb/tb_bk_ram_arbiter.sv
// Self-checking bench for bk_ram_arbiter: SRAM model, reference memory,
// directed scenarios and randomized CPU/video traffic.
module tb_bk_ram_arbiter;

    localparam int WS = 1;
    localparam int AW = 18;
    localparam int NW = 1 << (AW - 1);
    localparam logic [AW-2:0] RB = 17'h00400;
    localparam logic [AW-2:0] WR = 17'h00100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_rd = 1'b0;
    logic          cpu_wt = 1'b0;
    logic          cpu_byte = 1'b0;
    logic [AW-1:0] cpu_adr = '0;
    logic [15:0]   cpu_data_i = '0;
    logic [15:0]   cpu_data_o;
    logic          cpu_reply;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_adr = '0;
    logic [15:0]   vid_data;
    logic          vid_ack;
    logic [AW-2:0] sram_a;
    logic [15:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_i;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ub_n;
    logic          sram_lb_n;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] mem [0:NW-1];
    logic [15:0] ref_mem [0:NW-1];
    logic          pl_en = 1'b0;
    logic [AW-2:0] pl_addr = '0;
    logic [15:0]   pl_data = '0;

    logic m_last_vid = 1'b0;

    int       we_low_cnt = 0;
    logic [1:0] we_lanes = 2'b11;
    logic [1:0] rd_lanes = 2'b11;
    logic     prev_oe_n = 1'b1;
    logic     mon_en = 1'b0;
    logic     grants [$];
    logic [AW-2:0] mon_vw = '0;
    int       vid_ack_cnt = 0;
    logic [15:0] last_vdata = '0;

    always #5 clk = ~clk;

    bk_ram_arbiter #(.WAIT_STATES(WS), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_rd     (cpu_rd),
        .cpu_wt     (cpu_wt),
        .cpu_byte   (cpu_byte),
        .cpu_adr    (cpu_adr),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .cpu_reply  (cpu_reply),
        .vid_req    (vid_req),
        .vid_adr    (vid_adr),
        .vid_data   (vid_data),
        .vid_ack    (vid_ack),
        .sram_a     (sram_a),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    // SRAM model: asynchronous read, lane-masked write while we_n is low.
    assign sram_dq_i = sram_oe_n ? 16'hDEAD : mem[sram_a];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq_o[15:8];
        end
    end

    always @(negedge clk) begin
        if (!sram_we_n) begin
            we_low_cnt = we_low_cnt + 1;
            we_lanes   = {sram_ub_n, sram_lb_n};
        end
        if (!sram_oe_n) rd_lanes = {sram_ub_n, sram_lb_n};
        if (mon_en && prev_oe_n && !sram_oe_n)
            grants.push_back(sram_a == mon_vw);
        if (vid_ack) begin
            vid_ack_cnt = vid_ack_cnt + 1;
            last_vdata  = vid_data;
        end
        prev_oe_n = sram_oe_n;
    end

    function automatic void model_write(input logic [AW-1:0] adr,
                                        input logic bt,
                                        input logic [15:0] d);
        logic [AW-2:0] w;
        w = adr[AW-1:1];
        if (!bt)         ref_mem[w] = d;
        else if (adr[0]) ref_mem[w][15:8] = d[15:8];
        else             ref_mem[w][7:0] = d[7:0];
    endfunction

    task automatic preload(input logic [AW-2:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic cpu_access(input logic wr, input logic bt,
                              input logic [AW-1:0] adr,
                              input logic [15:0] d,
                              output logic [15:0] rd,
                              output int lat, output int rcyc);
        int t0;
        int n;
        @(negedge clk);
        cpu_wt = wr; cpu_rd = !wr; cpu_byte = bt;
        cpu_adr = adr; cpu_data_i = d;
        t0 = cyc; n = 0;
        do begin
            @(negedge clk); n++;
        end while (!cpu_reply && n < 60);
        if (n >= 60) begin
            n_cmp++; n_err++;
            $display("FAIL cpu_timeout: reply=%0b after %0d cycles, need 1", cpu_reply, n);
        end
        lat = cyc - t0; rcyc = cyc; rd = cpu_data_o;
        cpu_rd = 1'b0; cpu_wt = 1'b0;
    endtask

    task automatic vid_access(input logic [AW-1:0] adr,
                              output logic [15:0] vd,
                              output int lat, output int acyc);
        int t0;
        int n;
        @(negedge clk);
        vid_req = 1'b1; vid_adr = adr;
        t0 = cyc; n = 0;
        do begin
            @(negedge clk); n++;
        end while (!vid_ack && n < 60);
        if (n >= 60) begin
            n_cmp++; n_err++;
            $display("FAIL vid_timeout: ack=%0b after %0d cycles, need 1", vid_ack, n);
        end
        lat = cyc - t0; acyc = cyc; vd = vid_data;
        vid_req = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) preload(RB + 17'(i), 16'($urandom));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 5'b11110) begin
            n_err++;
            $display("FAIL reset_strobes: got %b need 11110",
                     {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
        end
        n_cmp++;
        if ({cpu_reply, vid_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_handshake: got %b need 00", {cpu_reply, vid_ack});
        end
        n_cmp++;
        if ({sram_a, cpu_data_o, vid_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: a=%h cpu=%h vid=%h need 0", sram_a, cpu_data_o, vid_data);
        end
        m_last_vid = 1'b0;
    endtask

    task automatic test_reset_mid_vrd();
        int t0;
        int n;
        @(negedge clk);
        vid_req = 1'b1; vid_adr = {RB + 17'd3, 1'b0};
        @(negedge clk);
        n_cmp++;
        if (sram_oe_n !== 1'b0) begin
            n_err++;
            $display("FAIL vrd_active: oe_n=%b need 0", sram_oe_n);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 5'b11110) begin
            n_err++;
            $display("FAIL midreset_strobes: got %b need 11110",
                     {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe});
        end
        @(negedge clk);
        reset = 1'b0;
        m_last_vid = 1'b0;
        t0 = cyc; n = 0;
        do begin
            @(negedge clk); n++;
        end while (!vid_ack && n < 60);
        vid_req = 1'b0;
        n_cmp++;
        if (cyc - t0 != WS + 2) begin
            n_err++;
            $display("FAIL post_reset_vid_lat: got %0d need %0d", cyc - t0, WS + 2);
        end
        n_cmp++;
        if (vid_data !== ref_mem[RB + 17'd3]) begin
            n_err++;
            $display("FAIL post_reset_vid_data: got %h need %h", vid_data, ref_mem[RB + 17'd3]);
        end
        m_last_vid = 1'b1;
    endtask

    task automatic test_word_read();
        logic [15:0] rd;
        int lat;
        int rc;
        preload(WR, 16'o123456);
        rd_lanes = 2'b11;
        cpu_access(1'b0, 1'b0, 18'o1000, 16'h0, rd, lat, rc);
        n_cmp++;
        if (lat != WS + 2) begin
            n_err++;
            $display("FAIL word_read_lat: got %0d need %0d", lat, WS + 2);
        end
        n_cmp++;
        if (rd !== 16'o123456) begin
            n_err++;
            $display("FAIL word_read_data: got %o need 123456", rd);
        end
        n_cmp++;
        if (rd_lanes !== 2'b00) begin
            n_err++;
            $display("FAIL word_read_lanes: ub/lb got %b need 00", rd_lanes);
        end
        m_last_vid = 1'b0;
    endtask

    task automatic test_byte_write_odd();
        logic [15:0] rd;
        int lat;
        int rc;
        preload(WR, 16'h1278);
        we_low_cnt = 0;
        cpu_access(1'b1, 1'b1, 18'o1001, 16'h5A5A, rd, lat, rc);
        model_write(18'o1001, 1'b1, 16'h5A5A);
        n_cmp++;
        if (lat != WS + 4) begin
            n_err++;
            $display("FAIL byte_write_lat: got %0d need %0d", lat, WS + 4);
        end
        n_cmp++;
        if (we_low_cnt != WS + 1) begin
            n_err++;
            $display("FAIL byte_write_we_cycles: got %0d need %0d", we_low_cnt, WS + 1);
        end
        n_cmp++;
        if (we_lanes !== 2'b01) begin
            n_err++;
            $display("FAIL byte_write_lanes: ub/lb got %b need 01", we_lanes);
        end
        n_cmp++;
        if (mem[WR] !== ref_mem[WR] || mem[WR] !== 16'h5A78) begin
            n_err++;
            $display("FAIL byte_write_mem: got %h need %h", mem[WR], ref_mem[WR]);
        end
        m_last_vid = 1'b0;
    endtask

    task automatic test_reply_hold();
        int n;
        int held;
        logic [AW-2:0] w;
        w = RB + 17'd5;
        we_low_cnt = 0;
        @(negedge clk);
        cpu_wt = 1'b1; cpu_byte = 1'b0; cpu_adr = {w, 1'b0}; cpu_data_i = 16'hC3A5;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!cpu_reply && n < 60);
        model_write({w, 1'b0}, 1'b0, 16'hC3A5);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_reply === 1'b1) held++;
        end
        n_cmp++;
        if (held != 5) begin
            n_err++;
            $display("FAIL reply_held: got %0d cycles need 5", held);
        end
        cpu_wt = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cpu_reply !== 1'b0) begin
            n_err++;
            $display("FAIL reply_drop: got %b need 0", cpu_reply);
        end
        n_cmp++;
        if (we_low_cnt != WS + 1) begin
            n_err++;
            $display("FAIL reply_hold_single_write: we low %0d need %0d", we_low_cnt, WS + 1);
        end
        n_cmp++;
        if (mem[w] !== ref_mem[w]) begin
            n_err++;
            $display("FAIL reply_hold_mem: got %h need %h", mem[w], ref_mem[w]);
        end
        m_last_vid = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [15:0] rd;
        logic [15:0] vd;
        int lat;
        int vlat;
        int rc;
        int ac;
        fork
            cpu_access(1'b0, 1'b0, {RB + 17'd7, 1'b0}, 16'h0, rd, lat, rc);
            vid_access({RB + 17'd8, 1'b1}, vd, vlat, ac);
        join
        n_cmp++;
        if (vlat != WS + 2) begin
            n_err++;
            $display("FAIL simul_vid_lat: got %0d need %0d", vlat, WS + 2);
        end
        n_cmp++;
        if (!(ac < rc)) begin
            n_err++;
            $display("FAIL simul_order: ack cyc %0d reply cyc %0d, need video first", ac, rc);
        end
        n_cmp++;
        if (vd !== ref_mem[RB + 17'd8] || rd !== ref_mem[RB + 17'd7]) begin
            n_err++;
            $display("FAIL simul_data: vid %h need %h cpu %h need %h",
                     vd, ref_mem[RB + 17'd8], rd, ref_mem[RB + 17'd7]);
        end
        m_last_vid = 1'b0;
    endtask

    task automatic test_fairness();
        logic [AW-2:0] fv;
        logic [AW-2:0] fc;
        int n;
        int base;
        fv = RB + 17'd1;
        fc = RB + 17'd2;
        mon_vw = fv;
        grants.delete();
        mon_en = 1'b1;
        base = vid_ack_cnt;
        @(negedge clk);
        vid_adr = {fv, 1'b0}; vid_req = 1'b1;
        cpu_adr = {fc, 1'b0}; cpu_byte = 1'b0; cpu_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(negedge clk); n++;
            end while (!(sram_oe_n == 1'b0 && sram_a == fc) && n < 40);
            n_cmp++;
            if (n - 1 > WS + 2) begin
                n_err++;
                $display("FAIL fair_cpu_wait[%0d]: got %0d need <= %0d", i, n - 1, WS + 2);
            end
            n = 0;
            do begin
                @(negedge clk); n++;
            end while (!cpu_reply && n < 40);
            n_cmp++;
            if (cpu_data_o !== ref_mem[fc]) begin
                n_err++;
                $display("FAIL fair_cpu_data[%0d]: got %h need %h", i, cpu_data_o, ref_mem[fc]);
            end
            cpu_rd = 1'b0;
            @(negedge clk);
            cpu_rd = (i < 2);
        end
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!vid_ack && n < 40);
        vid_req = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        n_cmp++;
        if (vid_ack_cnt - base != 4 || last_vdata !== ref_mem[fv]) begin
            n_err++;
            $display("FAIL fair_vid: acks %0d need 4, data %h need %h",
                     vid_ack_cnt - base, last_vdata, ref_mem[fv]);
        end
        n_cmp++;
        if (grants.size() != 7) begin
            n_err++;
            $display("FAIL fair_grant_count: got %0d need 7", grants.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (grants[i] !== ((i % 2) == 0)) begin
                    n_err++;
                    $display("FAIL fair_grant[%0d]: video=%b need %b", i, grants[i], (i % 2) == 0);
                end
            end
        end
        m_last_vid = 1'b1;
    endtask

    task automatic test_random();
        logic [AW-2:0] cw;
        logic [AW-2:0] vw;
        logic a0;
        logic va0;
        logic wr;
        logic bt;
        logic [7:0] b;
        logic [15:0] d;
        logic [15:0] rd;
        logic [15:0] vd;
        logic [15:0] pre;
        logic [15:0] expv;
        logic exp_vf;
        int kind;
        int lat;
        int vlat;
        int rc;
        int ac;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            cw = RB + 17'($urandom_range(0, 15));
            vw = RB + 17'($urandom_range(0, 15));
            a0 = 1'($urandom); va0 = 1'($urandom);
            wr = 1'($urandom); bt = 1'($urandom);
            b = 8'($urandom);
            d = bt ? {b, b} : 16'($urandom);
            case (kind)
                0, 1: begin
                    wr = (kind == 1);
                    cpu_access(wr, bt, {cw, a0}, d, rd, lat, rc);
                    n_cmp++;
                    if (lat != (wr ? WS + 4 : WS + 2)) begin
                        n_err++;
                        $display("FAIL rnd_cpu_lat[%0d]: wr=%b got %0d", i, wr, lat);
                    end
                    if (wr) begin
                        model_write({cw, a0}, bt, d);
                        n_cmp++;
                        if (mem[cw] !== ref_mem[cw]) begin
                            n_err++;
                            $display("FAIL rnd_write[%0d]: got %h need %h", i, mem[cw], ref_mem[cw]);
                        end
                    end else begin
                        n_cmp++;
                        if (rd !== ref_mem[cw]) begin
                            n_err++;
                            $display("FAIL rnd_read[%0d]: got %h need %h", i, rd, ref_mem[cw]);
                        end
                    end
                    m_last_vid = 1'b0;
                end
                2: begin
                    vid_access({vw, va0}, vd, vlat, ac);
                    n_cmp++;
                    if (vlat != WS + 2 || vd !== ref_mem[vw]) begin
                        n_err++;
                        $display("FAIL rnd_vid[%0d]: lat %0d data %h need %0d %h",
                                 i, vlat, vd, WS + 2, ref_mem[vw]);
                    end
                    m_last_vid = 1'b1;
                end
                default: begin
                    exp_vf = !m_last_vid;
                    pre = ref_mem[vw];
                    fork
                        cpu_access(wr, bt, {cw, a0}, d, rd, lat, rc);
                        vid_access({vw, va0}, vd, vlat, ac);
                    join
                    if (wr) model_write({cw, a0}, bt, d);
                    expv = exp_vf ? pre : ref_mem[vw];
                    n_cmp++;
                    if ((ac < rc) !== exp_vf) begin
                        n_err++;
                        $display("FAIL rnd_order[%0d]: video_first %b need %b", i, ac < rc, exp_vf);
                    end
                    n_cmp++;
                    if (vd !== expv) begin
                        n_err++;
                        $display("FAIL rnd_sim_vid[%0d]: got %h need %h", i, vd, expv);
                    end
                    n_cmp++;
                    if ((wr ? mem[cw] : rd) !== ref_mem[cw]) begin
                        n_err++;
                        $display("FAIL rnd_sim_cpu[%0d]: wr=%b got %h need %h",
                                 i, wr, wr ? mem[cw] : rd, ref_mem[cw]);
                    end
                    m_last_vid = ~exp_vf;
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_vrd();
        test_word_read();
        test_byte_write_odd();
        test_reply_hold();
        test_simultaneous();
        test_fairness();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
